// File: rtl/cpu_pkg.sv
// Shared pipeline types: arbiter state/owner encodings and default bus widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports, shared memory port and stall lines of the unified memory arbiter.
interface mem_port_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_f;
  logic              stall_m;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  // Pipeline stages plus memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch and memory stage;
// data has priority, with a starvation guard that periodically forces a fetch grant.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DONE  = DONE;

  localparam int WC_W = $clog2(MEM_LAT + 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [WC_W-1:0] LAT_LOAD   = WC_W'(MEM_LAT - 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

  logic [1:0]        state;
  arb_owner_t        owner;
  logic              we_q;
  logic [WC_W-1:0]   wait_cnt;
  logic [SC_W-1:0]   starve_cnt;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;

  function automatic logic fetch_wins(input logic if_r, input logic dm_r, input logic starved);
    return if_r & (~dm_r | starved);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      we_q        <= 1'b0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.if_req) starve_cnt <= '0;
          if (bus.if_req | bus.dm_req) begin
            state    <= S_ISSUE;
            mem_en_q <= 1'b1;
            // mem_addr/mem_wdata double as the grant latch; fetch leaves mem_wdata untouched.
            if (fetch_wins(bus.if_req, bus.dm_req, starve_cnt == STARVE_TOP)) begin
              owner      <= OWN_IF;
              we_q       <= 1'b0;
              mem_addr_q <= bus.if_addr;
              starve_cnt <= '0;
            end else begin
              owner       <= OWN_DM;
              we_q        <= bus.dm_we;
              mem_we_q    <= bus.dm_we;
              mem_addr_q  <= bus.dm_addr;
              mem_wdata_q <= bus.dm_wdata;
              if (bus.if_req) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= LAT_LOAD;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_DONE;
            if (owner == OWN_IF) begin
              if_rdata_q <= bus.mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (!we_q) dm_rdata_q <= bus.mem_rdata;
              dm_ack_q <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.stall_f   = bus.if_req & ~if_ack_q;
  assign bus.stall_m   = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random fetch/data traffic against a transaction-timeline reference model of the memory arbiter.
module tb_mem_port_arbiter;

  localparam int ML   = 2;
  localparam int SM   = 4;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(ML), .STARVE_MAX(SM)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: one access occupies edges g .. g+ML+2; next grant no earlier than g+ML+3.
  int          free_edge;
  bit          infl;
  int          g_edge;
  bit          own_if;
  bit          lat_we;
  int          starve;
  logic [31:0] md_v;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;
  bit          e_mem_en, e_mem_we, e_if_ack, e_dm_ack;
  int          n_if_grants, n_dm_grants;

  task automatic model_edge(input int n);
    bit pick_if;
    e_if_ack = 0; e_dm_ack = 0; e_mem_en = 0; e_mem_we = 0;
    if (!rst_n) begin
      infl = 0; free_edge = n + 1; starve = 0;
      e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
    end else begin
      if (infl && n == g_edge + ML + 1) begin
        if (own_if) begin
          e_if_rdata = md_v; e_if_ack = 1;
        end else begin
          if (!lat_we) e_dm_rdata = md_v;
          e_dm_ack = 1;
        end
        infl = 0;
      end
      if (n >= free_edge) begin
        if (!bus.if_req) starve = 0;
        if (bus.if_req || bus.dm_req) begin
          pick_if = bus.if_req && (!bus.dm_req || starve == SM);
          if (pick_if) begin
            starve = 0; own_if = 1; lat_we = 0; e_addr = bus.if_addr;
            n_if_grants++;
          end else begin
            if (bus.if_req) starve++;
            own_if = 0; lat_we = bus.dm_we; e_addr = bus.dm_addr; e_wdata = bus.dm_wdata;
            n_dm_grants++;
          end
          infl = 1; g_edge = n; free_edge = n + ML + 3;
          e_mem_en = 1; e_mem_we = lat_we;
        end
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 65535)) << 2;
  endfunction

  initial begin
    bit hold;
    rst_n = 1'b0;
    md_v  = '0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_rdata = '0;
    free_edge = 0; infl = 0; g_edge = 0; own_if = 0; lat_we = 0; starve = 0;
    n_if_grants = 0; n_dm_grants = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge(cyc);
      #1;
      chk("mem_en",   32'(bus.mem_en),  32'(e_mem_en));
      chk("mem_we",   32'(bus.mem_we),  32'(e_mem_we));
      chk("mem_addr", bus.mem_addr,     e_addr);
      if (e_mem_en && e_mem_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("if_ack",   32'(bus.if_ack),  32'(e_if_ack));
      chk("dm_ack",   32'(bus.dm_ack),  32'(e_dm_ack));
      chk("if_rdata", bus.if_rdata,     e_if_rdata);
      chk("dm_rdata", bus.dm_rdata,     e_dm_rdata);

      // Next-cycle stimulus; the long hold window keeps both requests up to exercise starvation.
      hold  = (cyc >= 2000 && cyc < 2600);
      rst_n = !(cyc < 1 || (!hold && (cyc % 250) == 131));
      md_v  = $urandom;
      bus.mem_rdata = md_v;

      if (e_if_ack) begin
        bus.if_req  = hold || ($urandom_range(0, 1) == 1);
        bus.if_addr = rnd_addr();
      end else if (!bus.if_req) begin
        if (hold || $urandom_range(0, 3) == 0) begin
          bus.if_req = 1; bus.if_addr = rnd_addr();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.if_addr = rnd_addr();
      end

      if (e_dm_ack || !bus.dm_req) begin
        if (e_dm_ack) bus.dm_req = hold || ($urandom_range(0, 1) == 1);
        else          bus.dm_req = hold || ($urandom_range(0, 2) == 0);
        bus.dm_addr  = rnd_addr() | 32'h8000_0000;
        bus.dm_we    = $urandom_range(0, 1) == 1;
        bus.dm_wdata = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.dm_addr  = rnd_addr() | 32'h8000_0000;
        bus.dm_we    = $urandom_range(0, 1) == 1;
        bus.dm_wdata = $urandom;
      end

      #1;
      chk("stall_f", 32'(bus.stall_f), 32'(bus.if_req & ~e_if_ack));
      chk("stall_m", 32'(bus.stall_m), 32'(bus.dm_req & ~e_dm_ack));
    end

    // Both stages must have been served, otherwise the traffic never exercised arbitration.
    chk("if_grants_seen", 32'(n_if_grants > 20), 32'd1);
    chk("dm_grants_seen", 32'(n_dm_grants > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
